// File: rtl/conv_lsu_arbiter_if.sv
// Signal bundle between conv_lsu_arbiter, the core LSU, the convolution load engine and data memory.
// Defining CONV_ARB_STATS_EN adds the three statistics counters to the bundle.

// Request handshake: a request transfers in a cycle where req and ready are
// both high. A requester that sees ready low must hold req and addr stable
// until it is accepted. Responses (*_data_valid) have no back-pressure and are
// valid for exactly the cycle in which they are high.
interface conv_lsu_arbiter_if;
   logic        core_req_i;
   logic [31:0] core_addr_i;
   logic        core_ready_o;
   logic        core_data_valid_o;
   logic [31:0] core_data_o;

   logic        acc_req_i;
   logic [31:0] acc_addr_i;
   logic        acc_ready_o;
   logic        acc_data_valid_o;
   logic [31:0] acc_data_o;

   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic        mem_data_valid_i;
   logic [31:0] mem_data_i;

   logic        err_o;

`ifdef CONV_ARB_STATS_EN
   logic [31:0] stat_core_grants_o;
   logic [31:0] stat_acc_grants_o;
   logic [31:0] stat_full_cycles_o;
`endif

   modport slave (
`ifdef CONV_ARB_STATS_EN
      output stat_core_grants_o,
      output stat_acc_grants_o,
      output stat_full_cycles_o,
`endif
      input  core_req_i,
      input  core_addr_i,
      output core_ready_o,
      output core_data_valid_o,
      output core_data_o,
      input  acc_req_i,
      input  acc_addr_i,
      output acc_ready_o,
      output acc_data_valid_o,
      output acc_data_o,
      output mem_req_o,
      output mem_addr_o,
      input  mem_ready_i,
      input  mem_data_valid_i,
      input  mem_data_i,
      output err_o
   );

   modport master (
`ifdef CONV_ARB_STATS_EN
      input  stat_core_grants_o,
      input  stat_acc_grants_o,
      input  stat_full_cycles_o,
`endif
      output core_req_i,
      output core_addr_i,
      input  core_ready_o,
      input  core_data_valid_o,
      input  core_data_o,
      output acc_req_i,
      output acc_addr_i,
      input  acc_ready_o,
      input  acc_data_valid_o,
      input  acc_data_o,
      input  mem_req_o,
      input  mem_addr_o,
      output mem_ready_i,
      output mem_data_valid_i,
      output mem_data_i,
      input  err_o
   );
endinterface

// File: rtl/conv_lsu_arbiter.sv
// Shares one data-memory read port between the core LSU and the conv load engine, routing in-order responses by owner tag.
// Optional statistics counters are built when CONV_ARB_STATS_EN is defined.
module conv_lsu_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input logic               clk_i,
   input logic               rst_ni,
   conv_lsu_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   // One owner bit per in-flight read: 0 = core, 1 = accelerator.
   logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [STV_W-1:0]           starve_q, starve_d;
   logic                       err_q, err_d;

   logic full;
   logic empty;
   logic any_req;
   logic sel_acc;
   logic mem_req;
   logic issue;
   logic grant_c;
   logic grant_a;
   logic pop;
   logic head_acc;

   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      any_req  = bus.core_req_i | bus.acc_req_i;
      sel_acc  = bus.acc_req_i & ((starve_q == STV_MAX) | ~bus.core_req_i);
      mem_req  = ~full & any_req;
      issue    = mem_req & bus.mem_ready_i;
      grant_c  = issue & ~sel_acc;
      grant_a  = issue & sel_acc;
      pop      = bus.mem_data_valid_i & ~empty;
      head_acc = tag_q[rd_ptr_q];
   end

   assign bus.mem_req_o  = mem_req;
   assign bus.mem_addr_o = !mem_req ? 32'd0 : (sel_acc ? bus.acc_addr_i : bus.core_addr_i);

   assign bus.core_ready_o = grant_c;
   assign bus.acc_ready_o  = grant_a;

   // Responses are routed by the tag at the FIFO head in the same cycle.
   assign bus.core_data_valid_o = pop & ~head_acc;
   assign bus.acc_data_valid_o  = pop & head_acc;
   assign bus.core_data_o       = (pop & ~head_acc) ? bus.mem_data_i : 32'd0;
   assign bus.acc_data_o        = (pop & head_acc) ? bus.mem_data_i : 32'd0;

   assign bus.err_o = err_q;

   always_comb begin
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;
      err_d    = err_q;

      if (issue) begin
         tag_d[wr_ptr_q] = sel_acc;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({issue, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Counts cycles the accelerator loses to the core; idle cycles leave it alone.
      if (!bus.acc_req_i || grant_a) begin
         starve_d = '0;
      end else if (grant_c && (starve_q != STV_MAX)) begin
         starve_d = starve_q + STV_W'(1);
      end

      if (bus.mem_data_valid_i && empty) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         tag_q    <= tag_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

`ifdef CONV_ARB_STATS_EN
   logic [31:0] stat_core_q, stat_core_d;
   logic [31:0] stat_acc_q, stat_acc_d;
   logic [31:0] stat_full_q, stat_full_d;

   // Free-running counters; they wrap silently on overflow.
   always_comb begin
      stat_core_d = stat_core_q + {31'd0, grant_c};
      stat_acc_d  = stat_acc_q + {31'd0, grant_a};
      stat_full_d = stat_full_q + {31'd0, full & any_req};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_core_q <= '0;
         stat_acc_q  <= '0;
         stat_full_q <= '0;
      end else begin
         stat_core_q <= stat_core_d;
         stat_acc_q  <= stat_acc_d;
         stat_full_q <= stat_full_d;
      end
   end

   assign bus.stat_core_grants_o = stat_core_q;
   assign bus.stat_acc_grants_o  = stat_acc_q;
   assign bus.stat_full_cycles_o = stat_full_q;
`endif

endmodule

// File: tb/tb_conv_lsu_arbiter.sv
// Bench for conv_lsu_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model and an end-to-end data scoreboard.
module tb_conv_lsu_arbiter;
  localparam int MAX   = 4;
  localparam int LIMIT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_lsu_arbiter_if bus ();

  conv_lsu_arbiter #(
    .MAX_OUTSTANDING(MAX),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: owners of in-flight reads in issue order.
  bit          m_owner[$];
  int          m_starve;
  bit          m_err;
  int unsigned m_sc, m_sa, m_sf;

  // Downstream memory and end-to-end scoreboard.
  logic [31:0] mem_pipe[$];
  logic [31:0] exp_core_q[$];
  logic [31:0] exp_acc_q[$];
  bit          sb_en = 1'b0;
  bit          c_acc = 1'b0;
  bit          a_acc = 1'b0;

  bit ga [27];
  int nc, na;
  bit t4_own [4];
  int guard;

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void predict(output bit mreq, output bit pick_a, output bit iss);
    bit full;
    full   = (m_owner.size() == MAX);
    pick_a = bus.acc_req_i && (m_starve == LIMIT || !bus.core_req_i);
    mreq   = !full && (bus.core_req_i || bus.acc_req_i);
    iss    = mreq && bus.mem_ready_i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit mreq, pa, iss;
    if (!rst_n) begin
      m_owner.delete();
      m_starve = 0;
      m_err    = 1'b0;
      m_sc     = 0;
      m_sa     = 0;
      m_sf     = 0;
    end else begin
      predict(mreq, pa, iss);
      if (m_owner.size() == MAX && (bus.core_req_i || bus.acc_req_i)) m_sf++;
      if (iss && !pa) m_sc++;
      if (iss && pa) m_sa++;
      if (bus.mem_data_valid_i) begin
        if (m_owner.size() > 0) void'(m_owner.pop_front());
        else m_err = 1'b1;
      end
      if (iss) m_owner.push_back(pa);
      if (!bus.acc_req_i || (iss && pa)) m_starve = 0;
      else if (iss) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    end
  end

  // Compare process: every cycle out of reset, plus scoreboard bookkeeping.
  always @(negedge clk) begin
    bit mreq, pa, iss, rv, ra;
    logic [31:0] eaddr;
    if (rst_n) begin
      predict(mreq, pa, iss);
      eaddr = mreq ? (pa ? bus.acc_addr_i : bus.core_addr_i) : 32'd0;
      rv = bus.mem_data_valid_i && (m_owner.size() > 0);
      ra = 1'b0;
      if (rv) ra = m_owner[0];
      chk("mem_req", bus.mem_req_o, mreq);
      chk("mem_addr", bus.mem_addr_o, eaddr);
      chk("core_ready", bus.core_ready_o, iss && !pa);
      chk("acc_ready", bus.acc_ready_o, iss && pa);
      chk("core_dv", bus.core_data_valid_o, rv && !ra);
      chk("acc_dv", bus.acc_data_valid_o, rv && ra);
      chk("core_data", bus.core_data_o, (rv && !ra) ? bus.mem_data_i : 32'd0);
      chk("acc_data", bus.acc_data_o, (rv && ra) ? bus.mem_data_i : 32'd0);
      chk("err", bus.err_o, m_err);
`ifdef CONV_ARB_STATS_EN
      chk("stat_core", bus.stat_core_grants_o, m_sc);
      chk("stat_acc", bus.stat_acc_grants_o, m_sa);
      chk("stat_full", bus.stat_full_cycles_o, m_sf);
`endif
      c_acc = bus.core_ready_o;
      a_acc = bus.acc_ready_o;
      if (sb_en) begin
        if (bus.core_data_valid_o) begin
          if (exp_core_q.size() > 0) chk("sb_core_data", bus.core_data_o, exp_core_q.pop_front());
          else begin total++; bad++; $display("FAIL sb_core_extra: got %h, want no response", bus.core_data_o); end
        end
        if (bus.acc_data_valid_o) begin
          if (exp_acc_q.size() > 0) chk("sb_acc_data", bus.acc_data_o, exp_acc_q.pop_front());
          else begin total++; bad++; $display("FAIL sb_acc_extra: got %h, want no response", bus.acc_data_o); end
        end
        if (bus.mem_req_o && bus.mem_ready_i) mem_pipe.push_back(bus.mem_addr_o);
        if (bus.core_ready_o) exp_core_q.push_back(resp_of(bus.core_addr_i));
        if (bus.acc_ready_o) exp_acc_q.push_back(resp_of(bus.acc_addr_i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cr, input logic [31:0] ca, input bit ar, input logic [31:0] aa,
                       input bit mr, input bit dv, input logic [31:0] d);
    bus.core_req_i       = cr;
    bus.core_addr_i      = ca;
    bus.acc_req_i        = ar;
    bus.acc_addr_i       = aa;
    bus.mem_ready_i      = mr;
    bus.mem_data_valid_i = dv;
    bus.mem_data_i       = d;
  endtask

  task automatic rand_step(input bit stop);
    if (!bus.core_req_i || c_acc) begin
      bus.core_req_i  = !stop && ($urandom_range(0, 2) != 0);
      bus.core_addr_i = $urandom() & 32'hFFFF_FFFC;
    end
    if (!bus.acc_req_i || a_acc) begin
      bus.acc_req_i  = !stop && ($urandom_range(0, 3) != 0);
      bus.acc_addr_i = $urandom() & 32'hFFFF_FFFC;
    end
    bus.mem_ready_i = stop || ($urandom_range(0, 3) != 0);
    if (mem_pipe.size() > 0 && (stop || $urandom_range(0, 2) != 0)) begin
      bus.mem_data_valid_i = 1'b1;
      bus.mem_data_i       = resp_of(mem_pipe.pop_front());
    end else begin
      bus.mem_data_valid_i = 1'b0;
      bus.mem_data_i       = $urandom();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_core_ready", bus.core_ready_o, 0);
    chk("rst_acc_ready", bus.acc_ready_o, 0);
    chk("rst_core_dv", bus.core_data_valid_o, 0);
    chk("rst_acc_dv", bus.acc_data_valid_o, 0);
    chk("rst_err", bus.err_o, 0);
    tick();

    // Core-only read of 0x100, response two cycles after issue.
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req_o, 1);
    chk("t1_mem_addr", bus.mem_addr_o, 32'h100);
    chk("t1_core_ready", bus.core_ready_o, 1);
    chk("t1_acc_ready", bus.acc_ready_o, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_core_dv", bus.core_data_valid_o, 1);
    chk("t1_core_data", bus.core_data_o, 32'hDEAD_BEEF);
    chk("t1_acc_dv", bus.acc_data_valid_o, 0);
    chk("t1_acc_data", bus.acc_data_o, 0);
    tick();

    // Both sides request continuously; accelerator wins every 9th issue.
    nc = 0;
    na = 0;
    for (int i = 0; i < 27; i++) begin
      drive(1, 32'h1000, 1, 32'h2000, 1, i > 0, 32'(i));
      @(negedge clk);
      ga[i] = bus.acc_ready_o;
      if (bus.acc_ready_o) na++;
      if (bus.core_ready_o) nc++;
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 32'h55);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t2_acc_9th", ga[8], 1);
    chk("t2_acc_18th", ga[17], 1);
    chk("t2_acc_27th", ga[26], 1);
    chk("t2_acc_grants", na, 3);
    chk("t2_core_grants", nc, 24);

    // Fill the tag FIFO; a same-cycle response must not unblock issue.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3000, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("t3_fill_ready", bus.core_ready_o, 1);
      tick();
    end
    @(negedge clk);
    chk("t3_full_req", bus.mem_req_o, 0);
    chk("t3_full_ready", bus.core_ready_o, 0);
    tick();
    drive(1, 32'h3000, 0, 0, 1, 1, 32'h11);
    @(negedge clk);
    chk("t3_pop_req", bus.mem_req_o, 0);
    chk("t3_pop_ready", bus.core_ready_o, 0);
    chk("t3_pop_dv", bus.core_data_valid_o, 1);
    tick();
    drive(1, 32'h3000, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t3_resume_req", bus.mem_req_o, 1);
    chk("t3_resume_ready", bus.core_ready_o, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 1, 32'(32'h20 + i));
      @(negedge clk);
      chk("t3_drain_dv", bus.core_data_valid_o, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Issue order C, A, A, C; responses 1..4 return to their owners.
    drive(1, 32'h200, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t4_c0_ready", bus.core_ready_o, 1);
    chk("t4_c0_addr", bus.mem_addr_o, 32'h200);
    tick();
    drive(0, 0, 1, 32'h300, 1, 0, 0);
    @(negedge clk);
    chk("t4_a1_ready", bus.acc_ready_o, 1);
    chk("t4_a1_addr", bus.mem_addr_o, 32'h300);
    tick();
    drive(0, 0, 1, 32'h304, 1, 0, 0);
    @(negedge clk);
    chk("t4_a2_ready", bus.acc_ready_o, 1);
    chk("t4_a2_addr", bus.mem_addr_o, 32'h304);
    tick();
    drive(1, 32'h204, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t4_c3_ready", bus.core_ready_o, 1);
    chk("t4_c3_addr", bus.mem_addr_o, 32'h204);
    tick();
    t4_own = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'(i + 1));
      @(negedge clk);
      chk("t4_core_dv", bus.core_data_valid_o, !t4_own[i]);
      chk("t4_acc_dv", bus.acc_data_valid_o, t4_own[i]);
      chk("t4_core_data", bus.core_data_o, t4_own[i] ? 32'd0 : 32'(i + 1));
      chk("t4_acc_data", bus.acc_data_o, t4_own[i] ? 32'(i + 1) : 32'd0);
      tick();
    end

    // Response with nothing outstanding sets the sticky error.
    drive(0, 0, 0, 0, 0, 1, 32'h0BAD);
    @(negedge clk);
    chk("t5_no_core_dv", bus.core_data_valid_o, 0);
    chk("t5_no_acc_dv", bus.acc_data_valid_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_err_set", bus.err_o, 1);
    tick();
    tick();
    @(negedge clk);
    chk("t5_err_sticky", bus.err_o, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_err_cleared", bus.err_o, 0);
    tick();
    drive(1, 32'h400, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 1, 32'h500, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'(32'h77 + i));
      @(negedge clk);
      chk("t5_drop_core_dv", bus.core_data_valid_o, 0);
      chk("t5_drop_acc_dv", bus.acc_data_valid_o, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_err_after_rst", bus.err_o, 1);
    tick();

`ifdef CONV_ARB_STATS_EN
    // Counters start from zero after the reset above: five core then three accelerator issues.
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 32'h600, i >= 5, 32'h700, 1, i > 0, 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_stat_core", bus.stat_core_grants_o, 5);
    chk("t6_stat_acc", bus.stat_acc_grants_o, 3);
    tick();
`endif

    // Random traffic with a modelled downstream memory.
    mem_pipe.delete();
    exp_core_q.delete();
    exp_acc_q.delete();
    c_acc = 1'b0;
    a_acc = 1'b0;
    sb_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      rand_step(1'b0);
      tick();
    end
    guard = 0;
    while ((bus.core_req_i || bus.acc_req_i || mem_pipe.size() > 0) && guard < 300) begin
      rand_step(1'b1);
      tick();
      guard++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    if (guard >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d cycles, want under 300", guard);
    end
    @(negedge clk);
    chk("sb_core_left", exp_core_q.size(), 0);
    chk("sb_acc_left", exp_acc_q.size(), 0);
    sb_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_lsu_arbiter.md
Name: conv_lsu_arbiter

Overview:
- Shares the single data-memory read port between the core LSU (port C) and the convolution accelerator's load engine (port A).
- Accepts requests from both sides, issues one request per cycle downstream, and tracks in-order outstanding reads in an owner-tag FIFO so each response returns to its issuer.
- Core has priority; a starvation counter bounds accelerator wait time.

Parameters:
- MAX_OUTSTANDING, 4, depth of owner-tag FIFO (max in-flight reads; power of 2, >=2)
- STARVE_LIMIT, 8, consecutive cycles A may be denied by C before A gets priority (>=1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core read request
- core_addr_i  in  32  core byte address
- core_ready_o  out  1  core request accepted this cycle
- core_data_valid_o  out  1  response for core
- core_data_o  out  32  response data for core
- acc_req_i  in  1  accelerator read request
- acc_addr_i  in  32  accelerator byte address
- acc_ready_o  out  1  accelerator request accepted this cycle
- acc_data_valid_o  out  1  response for accelerator
- acc_data_o  out  32  response data for accelerator
- mem_req_o  out  1  downstream request
- mem_addr_o  out  32  downstream address
- mem_ready_i  in  1  downstream accepts request
- mem_data_valid_i  in  1  downstream response, in issue order, >=1 cycle after acceptance
- mem_data_i  in  32  downstream response data
- err_o  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset: all outputs 0, FIFO empty, starve counter 0, err_o 0. Reset mid-operation discards all in-flight tags; responses arriving after reset set err_o.
- Request selection is combinational; grants are not registered. Tag FIFO, counters and err_o are registered.
- Not full (count < MAX_OUTSTANDING):
  - sel = A if acc_req_i && (starve == STARVE_LIMIT || !core_req_i); else C if core_req_i.
  - mem_req_o = core_req_i || acc_req_i.
  - mem_addr_o = selected address; 0 when no request.
- Full: mem_req_o = 0. A same-cycle pop does not unblock issue.
- Issue: mem_req_o && mem_ready_i. On issue, push the owner bit (0=C, 1=A) and pulse the selected side's ready_o for one cycle. The other side's ready_o stays 0, and it must hold req/addr.
- Starvation counter:
  - +1 (saturating at STARVE_LIMIT) each cycle acc_req_i is high and C is issued.
  - Cleared when A is issued or acc_req_i is low.
  - Unchanged on cycles with no issue.
- Response: mem_data_valid_i pops the FIFO head and drives that owner's data_valid_o=1 and data_o=mem_data_i, combinationally in the same cycle. The other side's data_o is 0.
- Simultaneous issue and response in one cycle: push and pop both occur; count unchanged.
- Response with FIFO empty: no data_valid_o, err_o set until reset.
- Pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- Macro: CONV_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_core_grants_o[31:0], stat_acc_grants_o[31:0], and stat_full_cycles_o[31:0].
  - Counters increment on C issue, A issue, and each cycle with the FIFO full and a request pending; they wrap on overflow and reset to 0.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Core only, addr 0x100, mem_ready_i=1, response 0xDEADBEEF 2 cycles later -> core_ready_o pulse, mem_addr_o=0x100, core_data_valid_o with 0xDEADBEEF; acc_data_valid_o stays 0.
- Both request continuously, STARVE_LIMIT=8 -> 8 C issues, then 1 A issue, pattern repeats; A never waits more than 9 issue cycles.
- MAX_OUTSTANDING=4, mem_ready_i=1, no responses -> 4 issues, then mem_req_o=0. A response arriving in the next cycle still blocks issue that cycle; issue resumes the following cycle.
- Interleaved issues C,A,A,C with responses 1,2,3,4 -> core gets 1 and 4, acc gets 2 and 3, in order.
- mem_data_valid_i with FIFO empty -> err_o=1 and stays 1. Assert rst_ni low mid-traffic with 2 tags in flight, then return those 2 responses -> both dropped, err_o=1.
- CONV_ARB_STATS_EN defined, 5 C and 3 A issues -> stat_core_grants_o=5, stat_acc_grants_o=3.
